coloring_gen: RTL and testbench

- Transmitter side of the colour-stream check: accepts requested colours and emits a stream that the downstream coloring checker never flags.
- Illegal requests are replaced by a legal substitute colour, and each replacement is reported.
- Sits between a stimulus/source block and the checker, using a valid/ready handshake on both sides.
- Colour encoding: 2'b00 red, 2'b01 green, 2'b10 blue, 2'b11 separator (ends the current segment).

---
 rtl/coloring_pkg.sv | 48 ++++
 rtl/color_legalizer.sv | 33 +++
 rtl/coloring_gen.sv | 107 ++++++++++
 tb/tb_coloring_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coloring_pkg.sv
// coloring_pkg
// Shared definitions for the colour-stream generator and any checker model
// that must agree with it on what a legal stream looks like.
//   - colour encodings (red, green, blue, segment separator)
//   - tracker encoding for the last emitted colour of the current segment
//   - colorToTrk(): maps an emitted colour onto its tracker value
//   - legal():      decides whether a requested colour may follow the tracker
package coloring_pkg;

  typedef logic [1:0] color_t;
  typedef logic [1:0] trk_t;

  // Width of the run counter; enough for the largest allowed MAX_RUN of 7.
  localparam int RUN_W = 3;

  localparam color_t COL_RED   = 2'b00;
  localparam color_t COL_GREEN = 2'b01;
  localparam color_t COL_BLUE  = 2'b10;
  localparam color_t COL_SEP   = 2'b11;

  localparam trk_t TRK_NONE  = 2'd0;
  localparam trk_t TRK_RED   = 2'd1;
  localparam trk_t TRK_GREEN = 2'd2;
  localparam trk_t TRK_BLUE  = 2'd3;

  // A separator has no tracker value of its own; it returns the segment to NONE.
  function automatic trk_t colorToTrk(input color_t c);
    case (c)
      COL_RED:   return TRK_RED;
      COL_GREEN: return TRK_GREEN;
      COL_BLUE:  return TRK_BLUE;
      default:   return TRK_NONE;
    endcase
  endfunction

  // Red and green may never touch, and no colour may repeat beyond maxRun
  // within one segment. Separators and the first beat of a segment are free.
  function automatic logic legal(input trk_t last, input logic [RUN_W-1:0] run,
                                 input color_t c, input logic [RUN_W-1:0] maxRun);
    if (c == COL_SEP) return 1'b1;
    if (last == TRK_NONE) return 1'b1;
    if ((c == COL_RED && last == TRK_GREEN) || (c == COL_GREEN && last == TRK_RED))
      return 1'b0;
    if (colorToTrk(c) == last && run == maxRun) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/color_legalizer.sv
// color_legalizer
// Combinational substitution stage: given the tracker state and a request,
// produce the colour to emit and flag whether it replaced the request.
//   last_i  : tracker value of the last emitted colour in this segment
//   run_i   : how many times last_i has been emitted in a row
//   color_i : requested colour
//   emit_o  : colour to emit
//   fixed_o : 1 when emit_o is a substitute
module color_legalizer
  import coloring_pkg::*;
#(
  parameter int MAX_RUN = 2
) (
  input  logic [1:0]       last_i,
  input  logic [RUN_W-1:0] run_i,
  input  logic [1:0]       color_i,
  output logic [1:0]       emit_o,
  output logic             fixed_o
);

  // An illegal red/green request can only happen while last is red or green,
  // so blue is always a safe substitute. An illegal blue means the blue run is
  // full, and red cannot conflict with blue.
  always_comb begin
    emit_o  = color_i;
    fixed_o = 1'b0;
    if (!legal(last_i, run_i, color_i, RUN_W'(MAX_RUN))) begin
      fixed_o = 1'b1;
      emit_o  = (color_i == COL_BLUE) ? COL_RED : COL_BLUE;
    end
  end

endmodule

// File: rtl/coloring_gen.sv
// coloring_gen
// Transmitter for the colour stream: accepts requested colours over a
// valid/ready handshake, replaces illegal ones with a legal substitute and
// registers the result with one cycle of latency.
//   clk, rst_n           : clock and synchronous active-low reset
//   in_color/valid/ready : request side
//   out_color/valid/ready: emitted stream
//   out_fixed            : current output beat is a substitute
//   sub_cnt              : saturating count of substitutions since reset
module coloring_gen
  import coloring_pkg::*;
#(
  parameter int MAX_RUN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       in_color,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       out_color,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_fixed,
  output logic [CNT_W-1:0] sub_cnt
);

  logic [1:0]       out_color_q, out_color_d;
  logic             out_valid_q, out_valid_d;
  logic             out_fixed_q, out_fixed_d;
  logic [CNT_W-1:0] sub_cnt_q, sub_cnt_d;
  trk_t             last_q, last_d;
  logic [RUN_W-1:0] run_q, run_d;

  logic [1:0] emitColor;
  logic       emitFixed;
  logic       accept;
  trk_t       emitTrk;

  color_legalizer #(.MAX_RUN(MAX_RUN)) u_legalizer (
    .last_i  (last_q),
    .run_i   (run_q),
    .color_i (in_color),
    .emit_o  (emitColor),
    .fixed_o (emitFixed)
  );

  // The output register can take a new beat whenever it is empty or its
  // current beat leaves this cycle.
  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign emitTrk  = colorToTrk(emitColor);

  // The tracker follows what was actually emitted, so a substitute starts or
  // extends its own run exactly as a requested colour would.
  always_comb begin
    out_color_d = out_color_q;
    out_valid_d = out_valid_q;
    out_fixed_d = out_fixed_q;
    sub_cnt_d   = sub_cnt_q;
    last_d      = last_q;
    run_d       = run_q;
    if (accept) begin
      out_color_d = emitColor;
      out_valid_d = 1'b1;
      out_fixed_d = emitFixed;
      if (emitFixed && sub_cnt_q != {CNT_W{1'b1}}) begin
        sub_cnt_d = sub_cnt_q + CNT_W'(1);
      end
      if (emitColor == COL_SEP) begin
        last_d = TRK_NONE;
        run_d  = '0;
      end else if (emitTrk == last_q) begin
        run_d = run_q + RUN_W'(1);
      end else begin
        last_d = emitTrk;
        run_d  = RUN_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_color_q <= COL_SEP;
      out_valid_q <= 1'b0;
      out_fixed_q <= 1'b0;
      sub_cnt_q   <= '0;
      last_q      <= TRK_NONE;
      run_q       <= '0;
    end else begin
      out_color_q <= out_color_d;
      out_valid_q <= out_valid_d;
      out_fixed_q <= out_fixed_d;
      sub_cnt_q   <= sub_cnt_d;
      last_q      <= last_d;
      run_q       <= run_d;
    end
  end

  assign out_color = out_color_q;
  assign out_valid = out_valid_q;
  assign out_fixed = out_fixed_q;
  assign sub_cnt   = sub_cnt_q;

endmodule

// File: tb/tb_coloring_gen.sv
// tb_coloring_gen
// Directed bench for coloring_gen. Two instances: the default one
// (MAX_RUN=2, CNT_W=8) and a narrow one (MAX_RUN=1, CNT_W=2) for the
// no-repeat and counter-saturation cases. Expected beats are queued when a
// request is accepted and compared by a monitor when the beat is consumed.
module tb_coloring_gen;

  localparam logic [1:0] R = 2'b00, G = 2'b01, B = 2'b10, S = 2'b11;

  typedef struct packed {
    logic [1:0] color;
    logic       fixed;
    logic [7:0] cnt;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [1:0] in_color = 2'b00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] out_color;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_fixed;
  logic [7:0] sub_cnt;

  logic [1:0] in_color2 = 2'b00;
  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic [1:0] out_color2;
  logic       out_valid2;
  logic       out_ready2 = 1'b1;
  logic       out_fixed2;
  logic [1:0] sub_cnt2;

  beat_t expQ[$];
  beat_t expQ2[$];

  int testCount = 0;
  int failCount = 0;

  coloring_gen #(.MAX_RUN(2), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_color  (in_color),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_color (out_color),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fixed (out_fixed),
    .sub_cnt   (sub_cnt)
  );

  coloring_gen #(.MAX_RUN(1), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_color  (in_color2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .out_color (out_color2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .out_fixed (out_fixed2),
    .sub_cnt   (sub_cnt2)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // One comparison: count it, and report a FAIL line if it differs.
  task automatic checkOutput(input string name, input logic [10:0] actual,
                             input logic [10:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request on the chosen instance (starting just after a rising
  // edge), wait a bounded time for in_ready, queue the expected beat and let
  // the accepting edge pass. Leaves in_valid low just after that edge.
  task automatic applyStimulus(input bit second, input logic [1:0] req,
                               input logic [1:0] expColor, input logic expFixed,
                               input logic [7:0] expCnt);
    bit rdy;
    rdy = 1'b0;
    if (second) begin
      in_color2 = req;
      in_valid2 = 1'b1;
    end else begin
      in_color = req;
      in_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = second ? in_ready2 : in_ready;
      if (rdy) break;
    end
    if (!rdy) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL acceptTimeout: got in_ready 0, expected 1 within 20 cycles");
    end else if (second) begin
      expQ2.push_back('{expColor, expFixed, expCnt});
    end else begin
      expQ.push_back('{expColor, expFixed, expCnt});
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor for the default instance: every consumed beat must match the
  // oldest expectation in its queue.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedBeat", {out_color, out_fixed, sub_cnt}, 11'h7ff);
      end else begin
        e = expQ.pop_front();
        checkOutput("beat", {out_color, out_fixed, sub_cnt}, {e.color, e.fixed, e.cnt});
      end
    end
  end

  // Monitor for the narrow instance; its 2-bit counter is zero-extended.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && out_valid2 && out_ready2) begin
      if (expQ2.size() == 0) begin
        checkOutput("unexpectedBeat2", {out_color2, out_fixed2, 6'd0, sub_cnt2}, 11'h7ff);
      end else begin
        e = expQ2.pop_front();
        checkOutput("beat2", {out_color2, out_fixed2, 6'd0, sub_cnt2},
                    {e.color, e.fixed, e.cnt});
      end
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: each group is hand-computed against MAX_RUN.
  initial begin
    rst_n = 1'b0;
    idle(2);
    checkOutput("resetValid", {10'd0, out_valid}, 11'd0);
    checkOutput("resetColor", {9'd0, out_color}, 11'd3);
    checkOutput("resetFixed", {10'd0, out_fixed}, 11'd0);
    checkOutput("resetCnt", {3'd0, sub_cnt}, 11'd0);
    checkOutput("resetInReady", {10'd0, in_ready}, 11'd1);
    rst_n = 1'b1;

    // Third red exceeds the run of two; separator clears the segment.
    applyStimulus(0, R, R, 0, 8'd0);
    applyStimulus(0, R, R, 0, 8'd0);
    applyStimulus(0, R, B, 1, 8'd1);
    applyStimulus(0, S, S, 0, 8'd1);

    // Green straight after red is replaced; after a separator it is fine.
    applyStimulus(0, R, R, 0, 8'd1);
    applyStimulus(0, G, B, 1, 8'd2);
    applyStimulus(0, S, S, 0, 8'd2);
    applyStimulus(0, G, G, 0, 8'd2);

    // Blue run: third blue becomes red, the fourth blue is legal again.
    applyStimulus(0, B, B, 0, 8'd2);
    applyStimulus(0, B, B, 0, 8'd2);
    applyStimulus(0, B, R, 1, 8'd3);
    applyStimulus(0, B, B, 0, 8'd3);
    idle(1);

    // Stall: hold a green beat, offer red for three cycles and check that
    // nothing is accepted and the output holds. The red then follows green
    // and becomes blue, showing the stalled offer left the tracker alone.
    out_ready = 1'b0;
    applyStimulus(0, G, G, 0, 8'd3);
    in_color = R;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stallInReady", {10'd0, in_ready}, 11'd0);
      checkOutput("stallHold", {8'd0, out_valid, out_color}, {8'd0, 1'b1, G});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(0, R, B, 1, 8'd4);
    idle(1);

    // Reset while a beat is held: the beat is dropped and counts clear.
    out_ready = 1'b0;
    applyStimulus(0, R, R, 0, 8'd4);
    expQ.delete();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midResetValid", {10'd0, out_valid}, 11'd0);
    checkOutput("midResetCnt", {3'd0, sub_cnt}, 11'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    applyStimulus(0, G, G, 0, 8'd0);
    applyStimulus(0, R, B, 1, 8'd1);
    idle(1);

    // MAX_RUN=1: no repeats at all. Then an all-illegal stream saturates the
    // 2-bit counter at 3.
    applyStimulus(1, G, G, 0, 8'd0);
    applyStimulus(1, G, B, 1, 8'd1);
    applyStimulus(1, G, G, 0, 8'd1);
    applyStimulus(1, R, B, 1, 8'd2);
    applyStimulus(1, B, R, 1, 8'd3);
    applyStimulus(1, R, B, 1, 8'd3);
    applyStimulus(1, B, R, 1, 8'd3);
    applyStimulus(1, R, B, 1, 8'd3);
    idle(3);

    checkOutput("queueDrained", {10'd0, expQ.size() == 0}, 11'd1);
    checkOutput("queueDrained2", {10'd0, expQ2.size() == 0}, 11'd1);
    checkOutput("finalCnt2", {9'd0, sub_cnt2}, 11'd3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
